// File: rtl/rf_writeback_arbiter.sv
// Register-file write port arbiter: core writeback first, queued long-latency results fill free slots.
// Optional macro RF_WB_BYPASS_EN writes an ext result straight through when the queue is empty and the port is free.
module rf_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       core_we,
  input  logic [AW-1:0]              core_rd,
  input  logic [XLEN-1:0]            core_wd,
  input  logic                       ext_valid,
  output logic                       ext_ready,
  input  logic [AW-1:0]              ext_rd,
  input  logic [XLEN-1:0]            ext_wd,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_addr,
  output logic [XLEN-1:0]            rf_wd,
  input  logic [AW-1:0]              q1_addr,
  input  logic [AW-1:0]              q2_addr,
  output logic                       q1_busy,
  output logic                       q2_busy,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0]   ent_rd [DEPTH];
  logic [XLEN-1:0] ent_wd [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     occ;

  logic core_eff;
  logic xfer;
  logic bypass;
  logic push;
  logic pop;

  assign core_eff  = !areset && core_we && (core_rd != '0);
  assign ext_ready = !areset && (occ < FULL_CNT);
  assign xfer      = ext_valid && ext_ready;

`ifdef RF_WB_BYPASS_EN
  assign bypass = xfer && (ext_rd != '0) && (occ == '0) && !core_eff;
`else
  assign bypass = 1'b0;
`endif

  // rd==0 transfers are handshaken but never stored
  assign push = xfer && (ext_rd != '0) && !bypass;
  assign pop  = !areset && !core_eff && (occ != '0);

  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (areset) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      ent_vld <= '0;
    end else begin
      // squash older entries first; a same-edge push below is newer and survives
      for (int i = 0; i < DEPTH; i++) begin
        if (core_eff && (ent_rd[i] == core_rd)) ent_vld[i] <= 1'b0;
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail] <= ext_rd;
      ent_wd[tail] <= ext_wd;
    end
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_wd   = '0;
    if (core_eff) begin
      rf_we   = 1'b1;
      rf_addr = core_rd;
      rf_wd   = core_wd;
    end else if (bypass) begin
      rf_we   = 1'b1;
      rf_addr = ext_rd;
      rf_wd   = ext_wd;
    end else if (pop && ent_vld[head]) begin
      rf_we   = 1'b1;
      rf_addr = ent_rd[head];
      rf_wd   = ent_wd[head];
    end
  end

  always_comb begin
    q1_busy = 1'b0;
    q2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == q1_addr)) q1_busy = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == q2_addr)) q2_busy = 1'b1;
    end
    if (areset || (q1_addr == '0)) q1_busy = 1'b0;
    if (areset || (q2_addr == '0)) q2_busy = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: expected register-file writes are queued and checked by a monitor.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        areset;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wd;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_rd;
  logic [31:0] ext_wd;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  rf_writeback_arbiter #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
    .clk(clk), .areset(areset),
    .core_we(core_we), .core_rd(core_rd), .core_wd(core_wd),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_rd(ext_rd), .ext_wd(ext_wd),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cwe, input logic [4:0] crd, input logic [31:0] cwd,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ewd);
    @(posedge clk);
    #1;
    core_we = cwe; core_rd = crd; core_wd = cwd;
    ext_valid = ev; ext_rd = erd; ext_wd = ewd;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every register-file write must match the next expected write
  always @(negedge clk) begin
    if (areset === 1'b0 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at %0t", rf_addr, rf_wd, $time);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_addr, rf_wd} !== e) begin
          errors++;
          $display("FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h at %0t",
                   rf_addr, rf_wd, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    areset = 1'b1;
    core_we = 0; core_rd = 0; core_wd = 0;
    ext_valid = 0; ext_rd = 0; ext_wd = 0;
    q1_addr = 5'd3; q2_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rf_we", rf_we, 0);
    check("reset_ext_ready", ext_ready, 0);
    check("reset_occ", occupancy, 0);

    // Queue three entries while the core holds the port, then reset mid-queue
    drive(0, 0, 0, 0, 0, 0); areset = 1'b0; core_we = 1; core_rd = 1; core_wd = 32'h11;
    ext_valid = 1; ext_rd = 3; ext_wd = 32'h33; expw(1, 32'h11);
    @(negedge clk); check("ready_after_reset", ext_ready, 1);
    drive(1, 1, 32'h11, 1, 4, 32'h44); expw(1, 32'h11);
    drive(1, 1, 32'h11, 1, 6, 32'h66); expw(1, 32'h11);
    @(negedge clk); check("occ_two", occupancy, 2);
    drive(0, 0, 0, 0, 0, 0); areset = 1'b1;
    @(negedge clk);
    check("occ_before_reset_edge", occupancy, 3);
    check("rf_we_in_reset", rf_we, 0);
    check("ready_in_reset", ext_ready, 0);
    check("busy_in_reset", q1_busy, 0);
    drive(0, 0, 0, 0, 0, 0); areset = 1'b0;
    @(negedge clk);
    check("occ_after_reset", occupancy, 0);
    check("rf_we_after_reset", rf_we, 0);
    check("ready_after_mid_reset", ext_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("idle_rf_we", rf_we, 0);

    // Single ext result with idle core
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
`ifdef RF_WB_BYPASS_EN
    expw(5, 32'hDEADBEEF);
    @(negedge clk); check("bypass_rf_we", rf_we, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("bypass_occ", occupancy, 0);
`else
    @(negedge clk); check("enq_no_write", rf_we, 0);
    drive(0, 0, 0, 0, 0, 0); expw(5, 32'hDEADBEEF);
    @(negedge clk); check("enq_occ", occupancy, 1);
`endif
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("drained_occ", occupancy, 0);

    // Fill while core writes every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h11, 1, 5'(10 + i), 32'hA0 + i); expw(1, 32'h11);
    end
    @(negedge clk); check("ready_at_three", ext_ready, 1);
    q1_addr = 5'd12;
    drive(1, 1, 32'h11, 1, 14, 32'hFF); expw(1, 32'h11);
    @(negedge clk);
    check("full_ready", ext_ready, 0);
    check("full_occ", occupancy, 4);
    check("busy_x12", q1_busy, 1);
    drive(0, 0, 0, 0, 0, 0); expw(10, 32'hA0);
    @(negedge clk); check("full_popping_ready", ext_ready, 0);
    drive(0, 0, 0, 1, 20, 32'hB0); expw(11, 32'hA1);
    @(negedge clk); check("push_pop_ready", ext_ready, 1);
    drive(0, 0, 0, 0, 0, 0); expw(12, 32'hA2);
    @(negedge clk); check("push_pop_occ", occupancy, 3);
    drive(0, 0, 0, 0, 0, 0); expw(13, 32'hA3);
    drive(0, 0, 0, 0, 0, 0); expw(20, 32'hB0);
    @(negedge clk); check("occ_last", occupancy, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("occ_empty", occupancy, 0);

    // Squash: core overwrites a queued register
    q1_addr = 5'd7;
    drive(1, 1, 32'h11, 1, 7, 32'hAAAA); expw(1, 32'h11);
    drive(1, 7, 32'hBBBB, 0, 0, 0); expw(7, 32'hBBBB);
    @(negedge clk); check("busy_x7_queued", q1_busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("busy_x7_squashed", q1_busy, 0);
    check("squash_bubble", rf_we, 0);
    check("squash_occ", occupancy, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("squash_popped", occupancy, 0);

    // Same-edge core write and ext push to the same register
    q1_addr = 5'd9;
    drive(1, 9, 32'h1, 1, 9, 32'h2); expw(9, 32'h1);
    @(negedge clk); check("busy_x9_not_yet", q1_busy, 0);
    drive(1, 1, 32'h11, 0, 0, 0); expw(1, 32'h11);
    @(negedge clk);
    check("busy_x9_kept", q1_busy, 1);
    check("occ_x9", occupancy, 1);
    drive(0, 0, 0, 0, 0, 0); expw(9, 32'h2);
    @(negedge clk); check("busy_x9_draining", q1_busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("busy_x9_done", q1_busy, 0);

    // rd==0 ext transfer is discarded; core_rd==0 frees the port for a drain
    drive(0, 0, 0, 1, 0, 32'h1234);
    @(negedge clk); check("x0_ready", ext_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("x0_occ", occupancy, 0);
    q2_addr = 5'd15;
    drive(1, 1, 32'h11, 1, 15, 32'h15); expw(1, 32'h11);
    drive(1, 0, 32'h999, 0, 0, 0); expw(15, 32'h15);
    @(negedge clk); check("x15_busy", q2_busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("x15_occ", occupancy, 0);
    check("x15_busy_clear", q2_busy, 0);

    repeat (2) @(negedge clk);
    check("pending_expected_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
